// File: rtl/matmul4x4_scheduler.sv
// matmul4x4_scheduler
//
// Steps one shared row-by-column complex MAC unit over all 16 elements of
// C = A x B (4x4, complex). Elements are visited in row-major order. For each
// element the scheduler:
//   1. presents row i / column j to the operand muxes;
//   2. lets the muxes settle;
//   3. pulses the unit start;
//   4. waits for the unit done level;
//   5. writes the captured result to result storage at address {i,j}.
//
// Ports:
//   CLK, MasterReset        clock (rising edge), synchronous active-low reset
//   Enable                  low freezes all state; pending pulses are held off
//   Start, Abort            begin a full product (IDLE only) / return to IDLE
//   RowSel, ColSel          operand mux selects (i, j)
//   UnitStart               one-cycle start pulse to the row-column unit
//   UnitListo, UnitError    unit done level and overflow flag
//   UnitOutReal/Imag        unit result
//   WrEn, WrAddr            result write strobe and address {i,j}
//   WrReal, WrImag          registered result data
//   Busy, Done              not-IDLE level; one-cycle pulse at end of product
//   ErrorFlag, ErrorAddr    sticky error flag and address of the first error
//   TimedOut                sticky watchdog flag (MATMUL_SCHED_TIMEOUT_EN only)
//
// Optional build macro MATMUL_SCHED_TIMEOUT_EN adds an 8-bit WAIT-state
// watchdog (parameter TimeoutCycles) and the TimedOut output. Without it the
// scheduler waits for the unit indefinitely.

module matmul4x4_scheduler #(
   parameter int unsigned Width         = 8,
   parameter int unsigned SettleCycles  = 1
`ifdef MATMUL_SCHED_TIMEOUT_EN
   ,
   parameter int unsigned TimeoutCycles = 255
`endif
) (
   input  logic             CLK,
   input  logic             MasterReset,
   input  logic             Enable,
   input  logic             Start,
   input  logic             Abort,
   output logic [1:0]       RowSel,
   output logic [1:0]       ColSel,
   output logic             UnitStart,
   input  logic             UnitListo,
   input  logic             UnitError,
   input  logic [Width-1:0] UnitOutReal,
   input  logic [Width-1:0] UnitOutImag,
   output logic             WrEn,
   output logic [3:0]       WrAddr,
   output logic [Width-1:0] WrReal,
   output logic [Width-1:0] WrImag,
   output logic             Busy,
   output logic             Done,
   output logic             ErrorFlag,
   output logic [3:0]       ErrorAddr
`ifdef MATMUL_SCHED_TIMEOUT_EN
   ,
   output logic             TimedOut
`endif
);

   localparam logic [2:0] SettleLast = 3'(SettleCycles - 1);

   typedef enum logic [2:0] {
      StIdle,
      StSettle,
      StPulse,
      StWait,
      StWrite,
      StAdvance,
      StFinish
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       row_q, row_d;
   logic [1:0]       col_q, col_d;
   logic [2:0]       settle_cnt_q, settle_cnt_d;
   logic [Width-1:0] wr_real_q, wr_real_d;
   logic [Width-1:0] wr_imag_q, wr_imag_d;
   logic             err_flag_q, err_flag_d;
   logic [3:0]       err_addr_q, err_addr_d;

   logic             last_elem;
   logic             wd_expired;
   // Abort outranks Enable; both gate every state change.
   logic             step;

`ifdef MATMUL_SCHED_TIMEOUT_EN
   localparam logic [7:0] TimeoutLast = 8'(TimeoutCycles - 1);

   logic [7:0]       wd_q, wd_d;
   logic             timed_out_q, timed_out_d;

   assign wd_expired = (wd_q == TimeoutLast);
`else
   assign wd_expired = 1'b0;
`endif

   assign last_elem = ({row_q, col_q} == 4'hF);
   assign step      = Enable && !Abort;

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (!MasterReset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      if (Abort) begin
         state_d = StIdle;
      end else if (Enable) begin
         case (state_q)
            StIdle:    if (Start) state_d = StSettle;
            StSettle:  if (settle_cnt_q == SettleLast) state_d = StPulse;
            // Listo is not looked at here, so a stale level is never accepted.
            StPulse:   state_d = StWait;
            StWait:    if (UnitListo || wd_expired) state_d = StWrite;
            StWrite:   state_d = StAdvance;
            StAdvance: state_d = last_elem ? StFinish : StSettle;
            StFinish:  state_d = StIdle;
            default:   state_d = StIdle;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // FSM outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      UnitStart = MasterReset && step && (state_q == StPulse);
      WrEn      = MasterReset && step && (state_q == StWrite);
      Done      = MasterReset && step && (state_q == StFinish);
      Busy      = (state_q != StIdle);
      RowSel    = row_q;
      ColSel    = col_q;
      WrAddr    = {row_q, col_q};
      WrReal    = wr_real_q;
      WrImag    = wr_imag_q;
      ErrorFlag = err_flag_q;
      ErrorAddr = err_addr_q;
`ifdef MATMUL_SCHED_TIMEOUT_EN
      TimedOut  = timed_out_q;
`endif
   end

   // ---------------------------------------------------------------------------
   // Datapath next-state: indices, settle counter, result and error capture
   // ---------------------------------------------------------------------------
   always_comb begin
      row_d        = row_q;
      col_d        = col_q;
      settle_cnt_d = settle_cnt_q;
      wr_real_d    = wr_real_q;
      wr_imag_d    = wr_imag_q;
      err_flag_d   = err_flag_q;
      err_addr_d   = err_addr_q;
`ifdef MATMUL_SCHED_TIMEOUT_EN
      wd_d         = wd_q;
      timed_out_d  = timed_out_q;
`endif
      if (step) begin
         case (state_q)
            StIdle: begin
               if (Start) begin
                  row_d        = 2'd0;
                  col_d        = 2'd0;
                  settle_cnt_d = 3'd0;
                  err_flag_d   = 1'b0;
                  err_addr_d   = 4'd0;
`ifdef MATMUL_SCHED_TIMEOUT_EN
                  timed_out_d  = 1'b0;
`endif
               end
            end
            StSettle: begin
               if (settle_cnt_q != SettleLast) begin
                  settle_cnt_d = settle_cnt_q + 3'd1;
               end
            end
            StPulse: begin
`ifdef MATMUL_SCHED_TIMEOUT_EN
               wd_d = 8'd0;
`endif
            end
            StWait: begin
               if (UnitListo) begin
                  wr_real_d = UnitOutReal;
                  wr_imag_d = UnitOutImag;
                  // Only the first erroring element is recorded.
                  if (UnitError && !err_flag_q) begin
                     err_flag_d = 1'b1;
                     err_addr_d = {row_q, col_q};
                  end
               end
`ifdef MATMUL_SCHED_TIMEOUT_EN
               else if (wd_expired) begin
                  wr_real_d   = '0;
                  wr_imag_d   = '0;
                  timed_out_d = 1'b1;
                  err_flag_d  = 1'b1;
                  if (!err_flag_q) begin
                     err_addr_d = {row_q, col_q};
                  end
               end else begin
                  wd_d = wd_q + 8'd1;
               end
`endif
            end
            StAdvance: begin
               // On the last element the indices stay at (3,3) until next Start.
               if (!last_elem) begin
                  settle_cnt_d = 3'd0;
                  if (col_q == 2'd3) begin
                     col_d = 2'd0;
                     row_d = row_q + 2'd1;
                  end else begin
                     col_d = col_q + 2'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (!MasterReset) begin
         row_q        <= 2'd0;
         col_q        <= 2'd0;
         settle_cnt_q <= 3'd0;
         wr_real_q    <= '0;
         wr_imag_q    <= '0;
         err_flag_q   <= 1'b0;
         err_addr_q   <= 4'd0;
      end else begin
         row_q        <= row_d;
         col_q        <= col_d;
         settle_cnt_q <= settle_cnt_d;
         wr_real_q    <= wr_real_d;
         wr_imag_q    <= wr_imag_d;
         err_flag_q   <= err_flag_d;
         err_addr_q   <= err_addr_d;
      end
   end

`ifdef MATMUL_SCHED_TIMEOUT_EN
   always_ff @(posedge CLK) begin
      if (!MasterReset) begin
         wd_q        <= 8'd0;
         timed_out_q <= 1'b0;
      end else begin
         wd_q        <= wd_d;
         timed_out_q <= timed_out_d;
      end
   end
`endif

endmodule

// File: tb/tb_matmul4x4_scheduler.sv
// Directed bench for matmul4x4_scheduler. A behavioural row-column unit with
// a 5-cycle latency returns real=8*i+2*j, imag=i+j; a negedge monitor checks
// every write against that formula and in row-major order.

module tb_matmul4x4_scheduler;

   localparam int unsigned Width = 8;
   localparam int          Lat   = 5;

   logic             CLK = 1'b0;
   logic             MasterReset = 1'b0;
   logic             Enable = 1'b1;
   logic             Start = 1'b0;
   logic             Abort = 1'b0;
   logic [1:0]       RowSel, ColSel;
   logic             UnitStart;
   logic             UnitListo = 1'b0;
   logic             UnitError = 1'b0;
   logic [Width-1:0] UnitOutReal = '0;
   logic [Width-1:0] UnitOutImag = '0;
   logic             WrEn;
   logic [3:0]       WrAddr;
   logic [Width-1:0] WrReal, WrImag;
   logic             Busy, Done, ErrorFlag;
   logic [3:0]       ErrorAddr;
`ifdef MATMUL_SCHED_TIMEOUT_EN
   logic             TimedOut;
`endif

   int n_vec = 0;
   int n_err = 0;

   // Monitor / unit-model state
   int        cyc = 0;
   int        wr_cnt = 0, done_cnt = 0, pulse_cnt = 0;
   int        lat_cnt = 0, cur_addr = 0;
   bit [15:0] err_mask = '0;
   int        silent_addr = -1;
   int        abort_addr = -1;
   bit        abort_fired = 1'b0;
   int        drop_pulse_idx = -1, drop_write_idx = -1;
   bit        dropped_pulse = 1'b0, dropped_write = 1'b0;
   int        drop_cnt = 0;
   int        pulse_cyc3 = 0, wr_cyc3 = 0;

   always #5 CLK = ~CLK;

   matmul4x4_scheduler #(
      .Width         (Width),
      .SettleCycles  (1)
`ifdef MATMUL_SCHED_TIMEOUT_EN
      ,
      .TimeoutCycles (20)
`endif
   ) u_dut (
      .CLK         (CLK),
      .MasterReset (MasterReset),
      .Enable      (Enable),
      .Start       (Start),
      .Abort       (Abort),
      .RowSel      (RowSel),
      .ColSel      (ColSel),
      .UnitStart   (UnitStart),
      .UnitListo   (UnitListo),
      .UnitError   (UnitError),
      .UnitOutReal (UnitOutReal),
      .UnitOutImag (UnitOutImag),
      .WrEn        (WrEn),
      .WrAddr      (WrAddr),
      .WrReal      (WrReal),
      .WrImag      (WrImag),
      .Busy        (Busy),
      .Done        (Done),
      .ErrorFlag   (ErrorFlag),
      .ErrorAddr   (ErrorAddr)
`ifdef MATMUL_SCHED_TIMEOUT_EN
      ,
      .TimedOut    (TimedOut)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_real(input int a);
      if (a == silent_addr) return 0;
      return 32'(8 * (a / 4) + 2 * (a % 4));
   endfunction

   function automatic logic [31:0] exp_imag(input int a);
      if (a == silent_addr) return 0;
      return 32'(a / 4 + a % 4);
   endfunction

   // Enable/Abort injection, unit model and write monitor, all away from posedge.
   always @(negedge CLK) begin
      cyc++;
      if (Abort) Abort = 1'b0;
      if (drop_cnt > 0) begin
         drop_cnt--;
         if (drop_cnt == 0) Enable = 1'b1;
      end else if (Enable) begin
         if (UnitStart && pulse_cnt == drop_pulse_idx && !dropped_pulse) begin
            Enable = 1'b0; drop_cnt = 4; dropped_pulse = 1'b1;
         end else if (WrEn && wr_cnt == drop_write_idx && !dropped_write) begin
            Enable = 1'b0; drop_cnt = 4; dropped_write = 1'b1;
         end
      end
      #1;
      if (UnitStart) begin
         cur_addr  = int'({RowSel, ColSel});
         pulse_cnt++;
         UnitListo = 1'b0;
         UnitError = 1'b0;
         lat_cnt   = (cur_addr == silent_addr) ? 0 : Lat;
         if (cur_addr == 3) pulse_cyc3 = cyc;
      end else if (lat_cnt > 0) begin
         lat_cnt--;
         if (lat_cnt == 0) begin
            UnitListo   = 1'b1;
            UnitOutReal = Width'(8 * (cur_addr / 4) + 2 * (cur_addr % 4));
            UnitOutImag = Width'(cur_addr / 4 + cur_addr % 4);
            UnitError   = err_mask[cur_addr];
         end else if (cur_addr == abort_addr && !abort_fired && lat_cnt == Lat - 2) begin
            Abort = 1'b1; abort_fired = 1'b1;
         end
      end
      if (WrEn) begin
         check_val("wr_addr", WrAddr, 32'(wr_cnt & 15));
         check_val("wr_real", WrReal, exp_real(wr_cnt & 15));
         check_val("wr_imag", WrImag, exp_imag(wr_cnt & 15));
         if (WrAddr == 4'd3) wr_cyc3 = cyc;
         wr_cnt++;
      end
      if (Done) done_cnt++;
   end

   task automatic start_product();
      @(negedge CLK);
      wr_cnt = 0; done_cnt = 0; pulse_cnt = 0;
      Start = 1'b1;
      @(posedge CLK);
      #1;
      Start = 1'b0;
      check_val("busy_after_start", Busy, 1);
   endtask

   task automatic wait_done(input string tag);
      for (int k = 0; k < 2000 && done_cnt == 0; k++) @(negedge CLK);
      #2;
      check_val({tag, "_done_seen"}, 32'(done_cnt != 0), 1);
      repeat (3) @(negedge CLK);
      #2;
      check_val({tag, "_done_once"}, done_cnt, 1);
      check_val({tag, "_writes"}, wr_cnt, 16);
      check_val({tag, "_idle"}, Busy, 0);
   endtask

   initial begin
      // 1: reset
      MasterReset = 1'b0;
      repeat (2) @(negedge CLK);
      #2;
      check_val("rst_rowsel", RowSel, 0);
      check_val("rst_colsel", ColSel, 0);
      check_val("rst_wraddr", WrAddr, 0);
      check_val("rst_wrdata", {WrReal, WrImag}, 0);
      check_val("rst_pulses", {UnitStart, WrEn, Done}, 0);
      check_val("rst_busy", Busy, 0);
      check_val("rst_errflag", ErrorFlag, 0);
      check_val("rst_erraddr", ErrorAddr, 0);
`ifdef MATMUL_SCHED_TIMEOUT_EN
      check_val("rst_timedout", TimedOut, 0);
`endif
      MasterReset = 1'b1;

      // 2: clean run
      start_product();
      wait_done("plain");
      check_val("plain_errflag", ErrorFlag, 0);
      check_val("plain_pulses", pulse_cnt, 16);
      check_val("plain_hold_idx", WrAddr, 15);

      // 3: unit errors on elements 6 and 9
      err_mask = 16'h0240;
      start_product();
      wait_done("err");
      check_val("err_errflag", ErrorFlag, 1);
      check_val("err_erraddr", ErrorAddr, 6);
      err_mask = '0;

      // 4: Enable dropped during the 3rd PULSE and the 6th WRITE
      drop_pulse_idx = 2; drop_write_idx = 5;
      start_product();
      check_val("en_errflag_cleared", ErrorFlag, 0);
      wait_done("en");
      check_val("en_pulses", pulse_cnt, 16);
      check_val("en_drops", {dropped_pulse, dropped_write}, 2'b11);
      drop_pulse_idx = -1; drop_write_idx = -1;

      // 5: Abort while waiting on address 10 (error already flagged at 6)
      err_mask = 16'h0040; abort_addr = 10;
      start_product();
      for (int k = 0; k < 2000 && !abort_fired; k++) @(negedge CLK);
      check_val("abort_fired", abort_fired, 1);
      @(negedge CLK);
      #2;
      check_val("abort_idle", Busy, 0);
      repeat (30) @(negedge CLK);
      #2;
      check_val("abort_writes", wr_cnt, 10);
      check_val("abort_no_done", done_cnt, 0);
      check_val("abort_errflag", ErrorFlag, 1);
      check_val("abort_erraddr", ErrorAddr, 6);
      err_mask = '0; abort_addr = -1;
      start_product();
      check_val("restart_errflag", ErrorFlag, 0);
      wait_done("restart");

`ifdef MATMUL_SCHED_TIMEOUT_EN
      // 6: unit never answers element 3; watchdog writes 0/0 after 20 WAIT cycles
      silent_addr = 3;
      start_product();
      wait_done("tmo");
      check_val("tmo_timedout", TimedOut, 1);
      check_val("tmo_errflag", ErrorFlag, 1);
      check_val("tmo_erraddr", ErrorAddr, 3);
      check_val("tmo_wait_len", 32'(wr_cyc3 - pulse_cyc3), 21);
      silent_addr = -1;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/matmul4x4_scheduler.md
Name: matmul4x4_scheduler

Overview:
Sequences one shared row-by-column complex multiply-accumulate unit over all 16 elements of a 4x4 complex product C = A x B.
- Per element, selects row i of A and column j of B, pulses the unit's start, waits for its done flag, then writes the real and imaginary result to result storage.
- Sits between the top-level matrix controller (which issues Start and reads Done) and the row-column unit plus the operand and result memories.

Parameters:
Width, 8, bit width of each real and imaginary component.
SettleCycles, 1, idle cycles between operand select change and unit start pulse (range 1-7).
TimeoutCycles, 255, WAIT-state cycles before the watchdog fires (used only with the optional feature).

Ports:
CLK  in  1  system clock, rising edge.
MasterReset  in  1  synchronous, active-low reset.
Enable  in  1  high=advance; low=freeze all state, counters and outputs (pulses held off).
Start  in  1  begin a full 16-element product; sampled only in IDLE.
Abort  in  1  synchronous abort; return to IDLE, no Done.
RowSel  out  2  row index i presented to the A operand mux.
ColSel  out  2  column index j presented to the B operand mux.
UnitStart  out  1  one-cycle start pulse to the row-column unit.
UnitListo  in  1  unit done level.
UnitError  in  1  unit overflow flag, valid while UnitListo=1.
UnitOutReal  in  Width  unit real result.
UnitOutImag  in  Width  unit imaginary result.
WrEn  out  1  result write strobe, one cycle.
WrAddr  out  4  result address {i,j}.
WrReal  out  Width  registered real result.
WrImag  out  Width  registered imaginary result.
Busy  out  1  high in any state except IDLE.
Done  out  1  one-cycle pulse after the 16th write.
ErrorFlag  out  1  sticky; set if any element reported UnitError; cleared on a new accepted Start.
ErrorAddr  out  4  address of the first erroring element.

Behaviour:
- Reset (MasterReset=0 at a CLK edge) forces:
  - state IDLE;
  - RowSel, ColSel, WrAddr = 0;
  - WrReal, WrImag = 0;
  - UnitStart, WrEn, Busy, Done, ErrorFlag = 0;
  - ErrorAddr = 0.
- Reset has priority over Abort, and Abort has priority over Enable.
- States: IDLE, SETTLE, PULSE, WAIT, WRITE, ADVANCE, FINISH.
- IDLE: on Start=1, clear ErrorFlag and ErrorAddr, set i=j=0, go to SETTLE. Start in any other state is ignored.
- SETTLE: count SettleCycles cycles with RowSel=i and ColSel=j stable, then go to PULSE.
- PULSE: UnitStart=1 for exactly this cycle, then go to WAIT.
- WAIT: remain until UnitListo=1.
  - UnitListo is ignored in the PULSE cycle, so a stale Listo from the previous element cannot be accepted.
  - On UnitListo=1, register UnitOutReal into WrReal and UnitOutImag into WrImag.
  - If UnitError=1 and ErrorFlag=0: set ErrorFlag and load ErrorAddr={i,j}.
  - Go to WRITE.
- WRITE: WrEn=1 for one cycle with WrAddr={i,j}; go to ADVANCE.
- ADVANCE: order is row-major (j increments first).
  - If {i,j}=15: go to FINISH.
  - Else if j=3: j=0, i=i+1, then go to SETTLE.
  - Else: j=j+1, then go to SETTLE.
- FINISH: Done=1 for one cycle; go to IDLE.
- Index counters hold their final value (3,3) in IDLE until the next Start.
- Enable=0 in any state:
  - state, counters and registered outputs are held;
  - UnitStart, WrEn and Done are forced to 0 and the pending pulse is re-issued when Enable returns.
- Abort=1 in any non-IDLE state: next state IDLE; no WrEn or Done; ErrorFlag and ErrorAddr are retained.
- Errors never stop the sequence. All 16 elements are written, including erroring ones.
- Latency per element = SettleCycles + 1 (PULSE) + unit latency + 1 (WRITE) + 1 (ADVANCE), plus one FINISH cycle at the end of the product.

Optional Feature:
MATMUL_SCHED_TIMEOUT_EN
- Defined:
  - An 8-bit watchdog counts cycles spent in WAIT and is cleared on WAIT entry.
  - When it reaches TimeoutCycles without UnitListo, the scheduler sets ErrorFlag (and ErrorAddr if first), writes WrReal=WrImag=0 for that element, and continues via WRITE.
  - Adds output TimedOut (1 bit, sticky, cleared on accepted Start).
- Undefined: no counter and no TimedOut port; WAIT waits indefinitely.

Test Plan:
1. Reset with MasterReset=0 for 2 cycles, then Start=1 -> all outputs 0 during reset; Busy=1 the cycle after Start is accepted.
2. Full run, model unit with 5-cycle latency returning real=8*i+2*j and imag=i+j -> 16 WrEn pulses at WrAddr 0..15 in order, WrReal and WrImag matching the model per address; one Done pulse; ErrorFlag=0.
3. Model asserts UnitError on elements 6 and 9 -> ErrorFlag=1 and ErrorAddr=6 after Done; all 16 writes still occur.
4. Drop Enable for 4 cycles during PULSE and again during WRITE -> UnitStart and WrEn are delayed, not lost; exactly 16 writes total.
5. Abort=1 while WAIT for address 10 -> IDLE next cycle, no further WrEn, no Done; a following Start restarts from address 0 and clears ErrorFlag.
6. With MATMUL_SCHED_TIMEOUT_EN and TimeoutCycles=20, model never answers element 3 -> after 20 WAIT cycles, write of 0/0 at address 3; TimedOut=1, ErrorAddr=3; run completes with Done.
